// File: rtl/noc_input_port_if.sv
// Handshake/bus bundle for one router input port.
//   in_valid/in_data/in_full : upstream link (flit strobe, flit, backpressure)
//   grant/request            : switch arbiter handshake
//   flit_out/flit_valid      : crossbar input
//   err_timeout              : sticky grant-timeout flag
// master = upstream/arbiter side, slave = input port side.
interface noc_input_port_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_full;
  logic                  grant;
  logic [2:0]            request;
  logic [DATA_WIDTH-1:0] flit_out;
  logic                  flit_valid;
  logic                  err_timeout;

  modport master (
    output in_valid, in_data, grant,
    input  in_full, request, flit_out, flit_valid, err_timeout
  );

  modport slave (
    input  in_valid, in_data, grant,
    output in_full, request, flit_out, flit_valid, err_timeout
  );
endinterface

// File: rtl/noc_input_port.sv
// Router input stage: buffers single-flit packets in a FIFO, computes the XY
// route of the head flit, requests an output port from the switch arbiter and
// pops the head onto the crossbar when granted.
// Ports: clk, rst (async active-low), bus (noc_input_port_if.slave).
// Optional: define NOC_GRANT_TIMEOUT_EN to drop a head flit that waits
// TIMEOUT_CYCLES for a grant and raise the sticky err_timeout flag.
module noc_input_port #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned COORD_W        = 2,
  parameter int unsigned ROUTER_X       = 0,
  parameter int unsigned ROUTER_Y       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  noc_input_port_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] REQ_L    = 3'b000;
  localparam logic [2:0] REQ_E    = 3'b001;
  localparam logic [2:0] REQ_W    = 3'b010;
  localparam logic [2:0] REQ_N    = 3'b011;
  localparam logic [2:0] REQ_S    = 3'b100;
  localparam logic [2:0] REQ_NONE = 3'b111;

  typedef enum logic [1:0] {IDLE, ROUTE, WAIT_GRANT} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic                  in_full_q;
  logic                  wr_en, pop, load_flit, tmo_hit;
  state_t                state, state_nxt;
  logic [2:0]            request_q, request_nxt, route_req;
  logic                  flit_valid_q, flit_valid_nxt;
  logic [DATA_WIDTH-1:0] flit_out_q, head;
  logic [COORD_W-1:0]    dest_x, dest_y;

  assign head   = mem[rd_ptr];
  assign dest_x = head[DATA_WIDTH-1 -: COORD_W];
  assign dest_y = head[DATA_WIDTH-1-COORD_W -: COORD_W];

  // in_full is registered, so it is exactly the "FIFO already full" condition
  assign wr_en     = bus.in_valid && !in_full_q;
  assign count_nxt = count + CNT_W'(wr_en) - CNT_W'(pop);

  // XY routing, X dimension resolved first
  always_comb begin
    route_req = REQ_L;
    if (dest_x > COORD_W'(ROUTER_X))      route_req = REQ_E;
    else if (dest_x < COORD_W'(ROUTER_X)) route_req = REQ_W;
    else if (dest_y > COORD_W'(ROUTER_Y)) route_req = REQ_N;
    else if (dest_y < COORD_W'(ROUTER_Y)) route_req = REQ_S;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt      = state;
    request_nxt    = request_q;
    flit_valid_nxt = 1'b0;
    pop            = 1'b0;
    load_flit      = 1'b0;
    case (state)
      IDLE: begin
        request_nxt = REQ_NONE;
        if (count != '0) state_nxt = ROUTE;
      end
      ROUTE: begin
        request_nxt = route_req;
        state_nxt   = WAIT_GRANT;
      end
      WAIT_GRANT: begin
        if (bus.grant || tmo_hit) begin
          pop            = 1'b1;
          load_flit      = bus.grant;
          flit_valid_nxt = bus.grant;
          request_nxt    = REQ_NONE;
          // count after this pop, including a same-cycle write
          state_nxt      = ((count > CNT_W'(1)) || wr_en) ? ROUTE : IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        request_nxt = REQ_NONE;
      end
    endcase
  end

  // State, FIFO control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      request_q    <= REQ_NONE;
      flit_valid_q <= 1'b0;
      flit_out_q   <= '0;
      count        <= '0;
      in_full_q    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      state        <= state_nxt;
      request_q    <= request_nxt;
      flit_valid_q <= flit_valid_nxt;
      if (load_flit) flit_out_q <= head;
      count        <= count_nxt;
      in_full_q    <= (count_nxt == CNT_W'(FIFO_DEPTH));
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  // Flit storage; contents need no reset since pointers qualify them
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

`ifdef NOC_GRANT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the edge where the wait counter would reach TIMEOUT_CYCLES
  assign tmo_hit = (state == WAIT_GRANT) && !bus.grant &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Grant-wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ROUTE)                        tmo_cnt <= '0;
      else if (state == WAIT_GRANT && !bus.grant) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.request    = request_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.flit_out   = flit_out_q;
  assign bus.in_full    = in_full_q;

endmodule
